// File: rtl/fmap_reader.sv
// Raster-scan reader for the pooled feature-map bank: two adjacent pixels per beat, all channels,
// streamed through a 2-entry buffer. Define FMAP_ZERO_PAD_EN to add a 1-pixel zero border.
module fmap_reader #(
    parameter int OC         = 7,
    parameter int MAP_W      = 14,
    parameter int MAP_H      = 14,
    parameter int ROW_STRIDE = 14,
    parameter int BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 load,
    output logic [9:0]           addr1,
    output logic [9:0]           addr2,
    input  logic [(OC+1)*16-1:0] mem_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [(OC+1)*16-1:0] m_data,
    output logic [1:0]           m_mask,
    output logic                 m_last
);
    localparam int DW = (OC+1)*16;
`ifdef FMAP_ZERO_PAD_EN
    localparam int SW = MAP_W + 2;
    localparam int SH = MAP_H + 2;
    // Row pointer starts one row above the interior so padded row 1 lands on BASE_ADDR.
    localparam logic [9:0] ROW0 = 10'(BASE_ADDR - ROW_STRIDE);
`else
    localparam int SW = MAP_W;
    localparam int SH = MAP_H;
    localparam logic [9:0] ROW0 = 10'(BASE_ADDR);
`endif
    localparam int LAST_C = ((SW - 1) / 2) * 2;
    localparam int LAST_R = SH - 1;
    localparam bit ODD    = (SW % 2 == 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    mask;
        logic          last;
    } beat_t;

    state_t      state, state_nx;
    logic [6:0]  row, col;
    logic [9:0]  row_addr, a1;
    logic        last_pair, last_beat, half, issue, pop;
    logic [1:0]  occ;
    logic        rd_ptr, wr_ptr;
    logic        inf_vld, inf_last;
    logic [1:0]  inf_mask;
    beat_t       fifo [2];
    beat_t       wbeat, head;

    assign last_pair = (col == 7'(LAST_C));
    assign last_beat = last_pair && (row == 7'(LAST_R));
    assign half      = ODD && last_pair;
    assign head      = fifo[rd_ptr];
    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid && m_ready;
    // A slot is free if buffered + in-flight beats, less the one leaving now, stays below 2.
    assign issue     = (state == RUN) &&
                       (({1'b0, occ} + {2'b0, inf_vld}) < (3'd2 + {2'b0, pop}));

`ifdef FMAP_ZERO_PAD_EN
    logic       row_b, z0, z1;
    logic [1:0] inf_zero;
    assign row_b = (row == 7'd0) || (row == 7'(SH - 1));
    assign z0    = row_b || (col == 7'd0) || (col == 7'(SW - 1));
    assign z1    = row_b || (col >= 7'(SW - 2));
    assign a1    = row_addr + 10'(col) - 10'd1;
`else
    assign a1    = row_addr + 10'(col);
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue && last_beat) state_nx = DRAIN;
            DRAIN:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DRAIN) && pop && head.last;
`ifdef FMAP_ZERO_PAD_EN
        load  = issue && !(z0 && z1);
`else
        load  = issue;
`endif
        addr1 = '0;
        addr2 = '0;
        if (state == RUN) begin
            addr1 = a1;
            addr2 = half ? a1 : a1 + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || state == IDLE) begin
            row      <= '0;
            col      <= '0;
            row_addr <= ROW0;
        end else if (issue) begin
            if (last_pair) begin
                col      <= '0;
                row      <= row + 7'd1;
                row_addr <= row_addr + 10'(ROW_STRIDE);
            end else begin
                col <= col + 7'd2;
            end
        end
    end

    // One-deep read pipeline: tags travel alongside the memory access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inf_vld  <= 1'b0;
            inf_mask <= '0;
            inf_last <= 1'b0;
        end else begin
            inf_vld  <= issue;
            inf_mask <= half ? 2'b01 : 2'b11;
            inf_last <= last_beat;
        end
    end

`ifdef FMAP_ZERO_PAD_EN
    always_ff @(posedge clk) begin
        if (!rst) inf_zero <= '0;
        else      inf_zero <= {z1, z0};
    end
`endif

    always_comb begin
        wbeat.data = mem_data;
`ifdef FMAP_ZERO_PAD_EN
        for (int i = 0; i <= OC; i++) begin
            if (inf_zero[0]) wbeat.data[16*i +: 8]     = '0;
            if (inf_zero[1]) wbeat.data[16*i + 8 +: 8] = '0;
        end
`endif
        wbeat.mask = inf_mask;
        wbeat.last = inf_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            occ <= occ + {1'b0, inf_vld} - {1'b0, pop};
            if (inf_vld) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (inf_vld) fifo[wr_ptr] <= wbeat;
    end

    assign m_data = m_valid ? head.data : '0;
    assign m_mask = m_valid ? head.mask : '0;
    assign m_last = m_valid ? head.last : 1'b0;
endmodule

// File: tb/tb_fmap_reader.sv
// Scoreboard bench for fmap_reader: directed scans on two small map configurations.
module tb_fmap_reader;
    localparam int OC = 7;
    localparam int DW = (OC+1)*16;
`ifdef FMAP_ZERO_PAD_EN
    localparam int BW = 2, BH = 1, BRS = 2;
`else
    localparam int BW = 3, BH = 2, BRS = 3;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    mask;
        logic          last;
    } exp_t;

    logic          clk = 1'b0, rst, m_ready, start_a, start_b;
    logic          busy_a, done_a, load_a, mv_a, ml_a;
    logic          busy_b, done_b, load_b, mv_b, ml_b;
    logic [9:0]    a1_a, a2_a, a1_b, a2_b;
    logic [DW-1:0] mem_a, mem_b, md_a, md_b;
    logic [1:0]    mm_a, mm_b;

    exp_t sbq[$];
    int   cur = 0;
    int   n_chk = 0, n_fail = 0;
    int   nload_a = 0, nload_b = 0;
    int   pops_a = 0, dones_a = 0, dones_b = 0;
    logic hold_a = 1'b0;
    logic [DW-1:0] hold_data;
    logic [1:0]    hold_mask;

    always #5 clk = ~clk;

    fmap_reader #(.OC(OC), .MAP_W(4), .MAP_H(2), .ROW_STRIDE(4), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .load(load_a),
        .addr1(a1_a), .addr2(a2_a), .mem_data(mem_a), .m_valid(mv_a), .m_ready(m_ready),
        .m_data(md_a), .m_mask(mm_a), .m_last(ml_a));

    fmap_reader #(.OC(OC), .MAP_W(BW), .MAP_H(BH), .ROW_STRIDE(BRS), .BASE_ADDR(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .load(load_b),
        .addr1(a1_b), .addr2(a2_b), .mem_data(mem_b), .m_valid(mv_b), .m_ready(m_ready),
        .m_data(md_b), .m_mask(mm_b), .m_last(ml_b));

    function automatic logic [7:0] pix(input logic [9:0] a, input int ch);
        return 8'(int'(a) * 8 + ch + 1);
    endfunction

    function automatic logic [DW-1:0] pack(input logic [9:0] a1, input logic [9:0] a2,
                                           input logic [1:0] z);
        logic [DW-1:0] d;
        d = '0;
        for (int ch = 0; ch <= OC; ch++) begin
            d[16*ch +: 8]     = z[0] ? 8'h00 : pix(a1, ch);
            d[16*ch + 8 +: 8] = z[1] ? 8'h00 : pix(a2, ch);
        end
        return d;
    endfunction

    // Memory bank: data one cycle after load, garbage otherwise.
    always @(posedge clk) begin
        mem_a <= load_a ? pack(a1_a, a2_a, 2'b00) : {$urandom, $urandom, $urandom, $urandom};
        mem_b <= load_b ? pack(a1_b, a2_b, 2'b00) : {$urandom, $urandom, $urandom, $urandom};
        if (load_a) nload_a <= nload_a + 1;
        if (load_b) nload_b <= nload_b + 1;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [9:0] a1, input logic [9:0] a2, input logic [1:0] mask,
                            input logic last, input logic [1:0] z);
        exp_t e;
        e.data = pack(a1, a2, z);
        e.mask = mask;
        e.last = last;
        sbq.push_back(e);
    endtask

    task automatic mon_beat(input int k, input logic [DW-1:0] d, input logic [1:0] m,
                            input logic l, input logic dn);
        exp_t e;
        if (k != cur) begin
            check("unexpected_dut_beat", 1, 0);
        end else if (sbq.size() == 0) begin
            check("extra_beat", 1, 0);
        end else begin
            e = sbq.pop_front();
            check("beat_data", d, e.data);
            check("beat_mask", m, e.mask);
            check("beat_last", l, e.last);
            check("done_on_pop", dn, e.last);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mv_a && m_ready) begin
                mon_beat(0, md_a, mm_a, ml_a, done_a);
                pops_a++;
            end
            if (mv_b && m_ready) mon_beat(1, md_b, mm_b, ml_b, done_b);
            if (done_a) dones_a++;
            if (done_b) dones_b++;
            if (mv_a && !m_ready && hold_a) begin
                check("hold_data", md_a, hold_data);
                check("hold_mask", mm_a, hold_mask);
            end
        end
        hold_a    = rst && mv_a && !m_ready;
        hold_data = md_a;
        hold_mask = mm_a;
    end

    task automatic start_scan(input int k, output int lat);
        @(posedge clk); #1;
        if (k == 0) start_a = 1'b1; else start_b = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            lat++;
            if (lat == 1) check("busy_rise", (k == 0) ? busy_a : busy_b, 1);
            if ((k == 0) ? mv_a : mv_b) break;
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (n < 200 && (((k == 0) ? busy_a : busy_b) || sbq.size() != 0)) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", (n < 200), 1);
    endtask

    task automatic push_a_scan();
        exp_push(0, 1, 2'b11, 0, 2'b00);
        exp_push(2, 3, 2'b11, 0, 2'b00);
        exp_push(4, 5, 2'b11, 0, 2'b00);
        exp_push(6, 7, 2'b11, 1, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l0, d0, p0, n;
        rst = 1'b0; m_ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  busy_a, 0);
        check("rst_ctl",   {done_a, load_a, mv_a, ml_a}, 0);
        check("rst_addr",  {a1_a, a2_a}, 0);
        check("rst_mdata", md_a, 0);
        check("rst_mask",  mm_a, 0);
        rst = 1'b1;
        @(posedge clk); #1;

`ifndef FMAP_ZERO_PAD_EN
        // Free-flowing scan of the 4x2 map.
        cur = 0; l0 = nload_a; d0 = dones_a;
        push_a_scan();
        start_scan(0, lat);
        check("first_valid_latency", lat, 3);
        wait_idle(0);
        check("a_loads", nload_a - l0, 4);
        check("a_dones", dones_a - d0, 1);

        // Backpressure: only two reads outstanding, output held.
        m_ready = 1'b0; l0 = nload_a; d0 = dones_a;
        push_a_scan();
        start_scan(0, lat);
        repeat (8) @(posedge clk);
        #1;
        check("bp_loads", nload_a - l0, 2);
        check("bp_valid", mv_a, 1);
        m_ready = 1'b1;
        wait_idle(0);
        check("bp_total_loads", nload_a - l0, 4);
        check("bp_dones", dones_a - d0, 1);

        // Odd width: the last pair of each row carries one pixel.
        cur = 1; d0 = dones_b;
        exp_push(0, 1, 2'b11, 0, 2'b00);
        exp_push(2, 2, 2'b01, 0, 2'b00);
        exp_push(3, 4, 2'b11, 0, 2'b00);
        exp_push(5, 5, 2'b01, 1, 2'b00);
        start_scan(1, lat);
        wait_idle(1);
        check("b_dones", dones_b - d0, 1);

        // Reset during the second beat aborts the scan silently.
        cur = 0; d0 = dones_a; p0 = pops_a;
        push_a_scan();
        start_scan(0, lat);
        n = 0;
        while (pops_a == p0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_ctl", {done_a, load_a, mv_a, ml_a}, 0);
        check("mid_rst_out", md_a, 0);
        check("mid_rst_addr", {a1_a, a2_a, mm_a}, 0);
        sbq.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        push_a_scan();
        start_scan(0, lat);
        wait_idle(0);
        check("rst_scan_dones", dones_a - d0, 1);

        // Start pulses while busy are ignored.
        l0 = nload_a; d0 = dones_a;
        push_a_scan();
        start_scan(0, lat);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_idle(0);
        repeat (6) @(posedge clk);
        #1;
        check("busy_start_idle", busy_a, 0);
        check("busy_start_loads", nload_a - l0, 4);
        check("busy_start_dones", dones_a - d0, 1);
`else
        // 2x1 map padded to 4x3: border-only beats skip the memory.
        cur = 1; l0 = nload_b; d0 = dones_b;
        exp_push(0, 0, 2'b11, 0, 2'b11);
        exp_push(0, 0, 2'b11, 0, 2'b11);
        exp_push(1023, 0, 2'b11, 0, 2'b01);
        exp_push(1, 2, 2'b11, 0, 2'b10);
        exp_push(0, 0, 2'b11, 0, 2'b11);
        exp_push(0, 0, 2'b11, 1, 2'b11);
        start_scan(1, lat);
        check("pad_first_valid_latency", lat, 3);
        wait_idle(1);
        check("pad_loads", nload_b - l0, 2);
        check("pad_dones", dones_b - d0, 1);
`endif
        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fmap_reader.md
Name: fmap_reader

Overview:
- Read-side engine for the per-layer feature-map memory bank.
- Raster-scans a pooled map of MAP_W x MAP_H pixels and drives load/addr1/addr2 to fetch two horizontally adjacent pixels per beat across all OC+1 channels in parallel.
- Streams the results to the next conv stage over a valid/ready interface, with a 2-entry output buffer that absorbs backpressure.
- Counterpart of the layer store/pool path: that path writes and pools; this block reads pooled data out.

Parameters:
- OC, 7, highest channel index; channels 0..OC read in parallel.
- MAP_W, 14, pooled map width in pixels, 1..64.
- MAP_H, 14, pooled map height in rows, 1..64.
- ROW_STRIDE, 14, address step between rows (ROW_STRIDE >= MAP_W).
- BASE_ADDR, 0, address of pixel (0,0).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a scan when idle.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the final beat handshakes.
- load  output  1  read strobe to the memory bank.
- addr1  output  10  address of the left pixel.
- addr2  output  10  address of the right pixel.
- mem_data  input  (OC+1)*16  memory read data, valid the cycle after load. Channel i lane0 (addr1) is [16i+7:16i]; lane1 (addr2) is [16i+15:16i+8]; signed 8-bit.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  (OC+1)*16  beat data, same packing as mem_data.
- m_mask  output  2  bit0 = lane0 valid, bit1 = lane1 valid.
- m_last  output  1  high on the final beat of the scan.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE.
  - Outputs: busy=0, done=0, load=0, addr1=addr2=0, m_valid=0, m_data=0, m_mask=0, m_last=0.
  - Buffer emptied; in-flight read discarded.
  - Applies mid-scan; no done is produced for the aborted scan.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1. busy=1 from the next cycle.
  - RUN -> DRAIN in the cycle the last read is issued.
  - DRAIN -> IDLE when the last beat handshakes; done pulses in that same cycle.
- start while busy is ignored.
- Scan order: row r = 0..MAP_H-1, pair column c = 0,2,4,... < MAP_W.
  - addr1 = BASE_ADDR + r*ROW_STRIDE + c; addr2 = addr1 + 1.
  - Odd MAP_W, final pair of each row: addr2 = addr1, mask = 2'b01. Otherwise mask = 2'b11.
  - Beats per scan = MAP_H * ceil(MAP_W/2).
- Read issue rule: load=1 in a cycle only if (buffer occupancy + reads in flight) < 2, counting a same-cycle pop.
  - No more than 2 beats are ever outstanding.
  - No beat is ever dropped.
- Pipeline: load at cycle t; mem_data sampled at t+1 and written into the buffer; beat visible on m_valid at t+2.
  - Minimum latency start -> first m_valid is 3 cycles: start sampled at t0, load at t0+1, m_valid at t0+3.
- Throughput: 1 beat/cycle while m_ready=1.
- Buffer: 2-entry FIFO holding data, mask and last.
  - m_valid = not empty.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop keeps occupancy constant.
  - m_data/m_mask/m_last are held stable while m_valid=1 and m_ready=0.
- m_last = 1 only on the final beat. done follows that beat's handshake in the same cycle as the pop; busy falls the next cycle.
- Address arithmetic is 10-bit unsigned. Configurations whose last address exceeds 1023 are illegal and not checked.

Optional Feature:
- FMAP_ZERO_PAD_EN defined:
  - Scan covers (MAP_H+2) x (MAP_W+2), giving a 1-pixel zero border.
  - Border pixels read as 0 without issuing memory reads. A beat made entirely of border pixels uses no load and enters the buffer one cycle after it would have issued; the issue rule still applies.
  - Mixed beats read memory; border lanes are forced to 0.
  - Addresses are those of interior coordinates (r-1, c-1).
- Not defined: no padding; logic absent.

Test Plan:
- MAP_W=4, MAP_H=2, ROW_STRIDE=4, m_ready=1, pulse start -> loads (0,1),(2,3),(4,5),(6,7); 4 beats, mask=11; m_last on 4th; done same cycle; first m_valid 3 cycles after start.
- Same config, m_ready=0 for 10 cycles after start -> load stops after 2 issues; m_data stable; then release -> all 4 beats in order, none lost or duplicated.
- MAP_W=3, MAP_H=2 -> beats (0,1)m=11, (2,2)m=01, (3,4)m=11, (5,5)m=01 with ROW_STRIDE=3.
- rst=0 during 2nd beat, then start again -> no done for the aborted scan; new scan restarts at addr1=0; outputs zero during reset.
- start pulsed while busy -> ignored; exactly one done per accepted start.
- FMAP_ZERO_PAD_EN, MAP_W=2, MAP_H=1 -> 6 beats; first 2 beats are all-zero with no load; middle row beats carry memory data in interior lanes only.
